// File: rtl/operand_dispatcher_if.sv
// Bundle between a pair producer, the dispatcher, the arithmetic core and the result consumer.
// The slave modport is the dispatcher's view; the master modport is the environment's view.
interface operand_dispatcher_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] core_result;
  logic       res_valid;
  logic [7:0] res_data;
  logic       busy;

  modport slave (
    input  in_valid, in_a, in_b, core_result,
    output in_ready, start, op_a, op_b, res_valid, res_data, busy
  );

  modport master (
    output in_valid, in_a, in_b, core_result,
    input  in_ready, start, op_a, op_b, res_valid, res_data, busy
  );
endinterface

// File: rtl/operand_dispatcher.sv
// FIFO-buffered issue stage that sequences a handshake-less signed-arithmetic core by fixed latency.
// Optional macro OPERAND_HOLD_EN: op_a/op_b keep the last issued pair until the next issue.
module operand_dispatcher #(
  parameter int DEPTH     = 4,
  parameter int OP_CYCLES = 8
) (
  input logic                 clk,
  input logic                 rst,
  operand_dispatcher_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(OP_CYCLES);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] C_LOAD = CW'(OP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_CAPTURE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_start;
  logic          r_res_valid;
  logic          r_busy;
  logic [7:0]    r_op_a;
  logic [7:0]    r_op_b;
  logic [7:0]    r_res_data;
  logic [15:0]   w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic          w_run;
  logic          w_capture;
  logic          w_busy_next;

  assign w_push = bus.in_valid && r_in_ready;
  assign w_pop  = w_issue && (r_count != '0);
  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (AW+1)'(1);
      2'b01:   w_count_next = r_count - (AW+1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= {bus.in_a, bus.in_b};
    end
  end

  // in_ready comes from the next occupancy, so a pop never opens the input in its own cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != C_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (r_count != '0) w_state_next = S_ISSUE;
      S_ISSUE:   w_state_next = S_RUN;
      S_RUN:     if (r_cnt == '0) w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue     = (r_state == S_ISSUE);
    w_run       = (r_state == S_RUN);
    w_capture   = (r_state == S_CAPTURE);
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= C_LOAD;
    end else if (w_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Outputs lag the state by one cycle; the core result is sampled during CAPTURE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start     <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_start     <= w_issue;
      r_res_valid <= w_capture;
      r_busy      <= w_busy_next;
      if (w_capture) r_res_data <= bus.core_result;
      if (w_issue) begin
        r_op_a <= w_head[15:8];
        r_op_b <= w_head[7:0];
      end else begin
`ifdef OPERAND_HOLD_EN
        r_op_a <= r_op_a;
        r_op_b <= r_op_b;
`else
        r_op_a <= '0;
        r_op_b <= '0;
`endif
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.start     = r_start;
  assign bus.op_a      = r_op_a;
  assign bus.op_b      = r_op_b;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_operand_dispatcher.sv
// Bench for operand_dispatcher: a timing-rule reference model checks every output each cycle,
// and scenario tasks check latency, ordering, back-pressure and reset behaviour.
module tb_operand_dispatcher;
  localparam int DEPTH = 4;
  localparam int OPC   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_dispatcher_if u_if();

  operand_dispatcher #(.DEPTH(DEPTH), .OP_CYCLES(OPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: start of each pair = max(accept edge + 2, previous start + OPC + 3)
  int          cyc = 0;
  logic [15:0] q_pair[$];
  int          q_acc[$];
  int          next_free = 0;
  int          last_start = -1000;
  int          occ = 0;
  int          n_acc = 0;
  logic [7:0]  last_a = 0, last_b = 0, cap_val = 0;
  logic        exp_start = 0, exp_rv = 0, exp_busy = 0, exp_ready = 1;
  logic [7:0]  exp_a = 0, exp_b = 0, exp_rd = 0;
  int          st_cyc[$];
  logic [15:0] st_pair[$];
  int          rv_cnt = 0;

  initial begin
    u_if.in_valid    = 1'b0;
    u_if.in_a        = '0;
    u_if.in_b        = '0;
    u_if.core_result = '0;
  end

  always @(posedge clk) begin : model
    int hs;
    cyc++;
    if (rst) begin
      q_pair.delete(); q_acc.delete();
      next_free = 0; last_start = -1000; occ = 0;
      last_a = 0; last_b = 0;
      exp_start = 0; exp_rv = 0; exp_busy = 0; exp_ready = 1;
      exp_a = 0; exp_b = 0; exp_rd = 0;
    end else begin
      exp_start = 0;
      exp_rv    = 0;
      if (q_pair.size() > 0) begin
        hs = (q_acc[0] + 2 > next_free) ? q_acc[0] + 2 : next_free;
        if (hs == cyc) begin
          {last_a, last_b} = q_pair.pop_front();
          void'(q_acc.pop_front());
          last_start = cyc;
          next_free  = cyc + OPC + 3;
          exp_start  = 1;
          occ--;
        end
      end
      if (u_if.in_valid && exp_ready) begin
        q_pair.push_back({u_if.in_a, u_if.in_b});
        q_acc.push_back(cyc);
        occ++;
        n_acc++;
      end
      if (cyc == last_start + OPC + 1) begin
        exp_rv = 1;
        exp_rd = cap_val;
      end
      exp_ready = (occ < DEPTH);
`ifdef OPERAND_HOLD_EN
      exp_a = last_a;
      exp_b = last_b;
`else
      exp_a = exp_start ? last_a : 8'h00;
      exp_b = exp_start ? last_b : 8'h00;
`endif
      exp_busy = (cyc >= last_start) && (cyc <= last_start + OPC);
      if (q_pair.size() > 0) begin
        hs = (q_acc[0] + 2 > next_free) ? q_acc[0] + 2 : next_free;
        if (hs == cyc + 1) exp_busy = 1;
      end
    end
    #2;
    n_tests += 7;
    if (u_if.start !== exp_start) begin
      n_fail++; $display("FAIL model_start cyc=%0d got=%b exp=%b", cyc, u_if.start, exp_start);
    end
    if (u_if.op_a !== exp_a) begin
      n_fail++; $display("FAIL model_op_a cyc=%0d got=%h exp=%h", cyc, u_if.op_a, exp_a);
    end
    if (u_if.op_b !== exp_b) begin
      n_fail++; $display("FAIL model_op_b cyc=%0d got=%h exp=%h", cyc, u_if.op_b, exp_b);
    end
    if (u_if.res_valid !== exp_rv) begin
      n_fail++; $display("FAIL model_res_valid cyc=%0d got=%b exp=%b", cyc, u_if.res_valid, exp_rv);
    end
    if (u_if.res_data !== exp_rd) begin
      n_fail++; $display("FAIL model_res_data cyc=%0d got=%h exp=%h", cyc, u_if.res_data, exp_rd);
    end
    if (u_if.busy !== exp_busy) begin
      n_fail++; $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, u_if.busy, exp_busy);
    end
    if (u_if.in_ready !== exp_ready) begin
      n_fail++; $display("FAIL model_in_ready cyc=%0d got=%b exp=%b", cyc, u_if.in_ready, exp_ready);
    end
    if (u_if.start === 1'b1) begin
      st_cyc.push_back(cyc);
      st_pair.push_back({u_if.op_a, u_if.op_b});
    end
    if (u_if.res_valid === 1'b1) rv_cnt++;
    // Stub core: the product is valid only OPC cycles after start; noise otherwise
    if (cyc == last_start + OPC) begin
      cap_val = 8'(last_a * last_b);
      u_if.core_result = cap_val;
    end else begin
      u_if.core_result = 8'($urandom);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    u_if.in_valid = 1'b1;
    u_if.in_a = a;
    u_if.in_b = b;
    for (int i = 0; i < 200; i++) begin
      logic acc;
      acc = u_if.in_ready;
      tick();
      if (acc) begin
        u_if.in_valid = 1'b0;
        return;
      end
    end
    u_if.in_valid = 1'b0;
    n_tests++; n_fail++;
    $display("FAIL push_timeout got=no_accept exp=accept");
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 400; i++) begin
      if (q_pair.size() == 0 && cyc > last_start + OPC + 1) return;
      tick();
    end
    n_tests++; n_fail++;
    $display("FAIL drain_timeout got=busy exp=idle");
  endtask

  task automatic wait_start(output bit seen);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (u_if.start === 1'b1) begin
        seen = 1;
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL start_timeout got=no_start exp=start");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_tests += 6;
    if (u_if.busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", u_if.busy); end
    if (u_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", u_if.in_ready); end
    if (u_if.start !== 1'b0)    begin n_fail++; $display("FAIL reset_start got=%b exp=0", u_if.start); end
    if ({u_if.op_a, u_if.op_b} !== 16'h0) begin n_fail++; $display("FAIL reset_ops got=%h exp=0000", {u_if.op_a, u_if.op_b}); end
    if (u_if.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got=%b exp=0", u_if.res_valid); end
    if (u_if.res_data !== 8'h00) begin n_fail++; $display("FAIL reset_res_data got=%h exp=00", u_if.res_data); end
    tick();
  endtask

  task automatic test_single_op();
    int k, s, d;
    bit seen;
    wait_drained();
    push_pair(8'd4, 8'd3);
    k = cyc;
    wait_start(seen);
    if (!seen) return;
    s = cyc;
    n_tests += 3;
    if (s !== k + 2)          begin n_fail++; $display("FAIL single_start_latency got=%0d exp=%0d", s - k, 2); end
    if (u_if.op_a !== 8'd4)   begin n_fail++; $display("FAIL single_op_a got=%h exp=04", u_if.op_a); end
    if (u_if.op_b !== 8'd3)   begin n_fail++; $display("FAIL single_op_b got=%h exp=03", u_if.op_b); end
    tick();
    n_tests += 2;
    if (u_if.start !== 1'b0) begin n_fail++; $display("FAIL single_start_width got=%b exp=0", u_if.start); end
`ifdef OPERAND_HOLD_EN
    if ({u_if.op_a, u_if.op_b} !== 16'h0403) begin n_fail++; $display("FAIL single_ops_hold got=%h exp=0403", {u_if.op_a, u_if.op_b}); end
`else
    if ({u_if.op_a, u_if.op_b} !== 16'h0000) begin n_fail++; $display("FAIL single_ops_clear got=%h exp=0000", {u_if.op_a, u_if.op_b}); end
`endif
    d = -1;
    for (int i = 0; i < 30; i++) begin
      if (u_if.res_valid === 1'b1) begin d = cyc - s; break; end
      tick();
    end
    n_tests += 2;
    if (d != OPC + 1)           begin n_fail++; $display("FAIL single_result_latency got=%0d exp=%0d", d, OPC + 1); end
    if (u_if.res_data !== 8'd12) begin n_fail++; $display("FAIL single_res_data got=%h exp=0c", u_if.res_data); end
  endtask

  task automatic test_signed_passthrough();
    int s0, r0;
    wait_drained();
    s0 = st_cyc.size();
    r0 = rv_cnt;
    push_pair(8'd6, 8'hF8);
    push_pair(8'hFC, 8'd3);
    wait_drained();
    n_tests++;
    if (st_cyc.size() != s0 + 2) begin
      n_fail++; $display("FAIL signed_start_count got=%0d exp=2", st_cyc.size() - s0);
      return;
    end
    n_tests += 4;
    if (st_pair[s0] !== 16'h06F8)     begin n_fail++; $display("FAIL signed_first_pair got=%h exp=06f8", st_pair[s0]); end
    if (st_pair[s0+1] !== 16'hFC03)   begin n_fail++; $display("FAIL signed_second_pair got=%h exp=fc03", st_pair[s0+1]); end
    if (st_cyc[s0+1] - st_cyc[s0] != OPC + 3) begin
      n_fail++; $display("FAIL signed_cadence got=%0d exp=%0d", st_cyc[s0+1] - st_cyc[s0], OPC + 3);
    end
    if (rv_cnt != r0 + 2) begin n_fail++; $display("FAIL signed_result_count got=%0d exp=2", rv_cnt - r0); end
  endtask

  task automatic test_full_fifo();
    logic [15:0] pairs[7];
    int s0, r0, idx, before_refuse;
    bit seen;
    wait_drained();
    for (int i = 0; i < 7; i++) pairs[i] = 16'($urandom);
    s0 = st_cyc.size();
    r0 = rv_cnt;
    push_pair(pairs[0][15:8], pairs[0][7:0]);
    wait_start(seen);
    idx = 1;
    before_refuse = -1;
    u_if.in_valid = 1'b1;
    u_if.in_a = pairs[1][15:8];
    u_if.in_b = pairs[1][7:0];
    for (int i = 0; i < 200 && idx < 7; i++) begin
      logic acc;
      acc = u_if.in_ready;
      if (!acc && before_refuse < 0) before_refuse = idx - 1;
      tick();
      if (acc) begin
        idx++;
        if (idx < 7) begin
          u_if.in_a = pairs[idx][15:8];
          u_if.in_b = pairs[idx][7:0];
        end
      end
    end
    u_if.in_valid = 1'b0;
    wait_drained();
    n_tests += 3;
    if (before_refuse != DEPTH) begin n_fail++; $display("FAIL full_accepts_before_stall got=%0d exp=%0d", before_refuse, DEPTH); end
    if (st_cyc.size() != s0 + 7) begin n_fail++; $display("FAIL full_issue_count got=%0d exp=7", st_cyc.size() - s0); end
    if (rv_cnt != r0 + 7)        begin n_fail++; $display("FAIL full_result_count got=%0d exp=7", rv_cnt - r0); end
    if (st_cyc.size() == s0 + 7) begin
      for (int i = 0; i < 7; i++) begin
        n_tests++;
        if (st_pair[s0+i] !== pairs[i]) begin
          n_fail++; $display("FAIL full_order idx=%0d got=%h exp=%h", i, st_pair[s0+i], pairs[i]);
        end
      end
    end
  endtask

  task automatic test_simul_push_pop();
    logic [15:0] pairs[6];
    int s0;
    bit seen, found;
    wait_drained();
    for (int i = 0; i < 6; i++) pairs[i] = 16'($urandom);
    s0 = st_cyc.size();
    push_pair(pairs[0][15:8], pairs[0][7:0]);
    wait_start(seen);
    for (int i = 1; i < 5; i++) push_pair(pairs[i][15:8], pairs[i][7:0]);
    u_if.in_valid = 1'b1;
    u_if.in_a = pairs[5][15:8];
    u_if.in_b = pairs[5][7:0];
    found = 0;
    for (int i = 0; i < 40; i++) begin
      logic rdy_before;
      rdy_before = u_if.in_ready;
      tick();
      if (u_if.start === 1'b1) begin
        found = 1;
        n_tests += 2;
        if (rdy_before !== 1'b0)    begin n_fail++; $display("FAIL simul_ready_at_pop got=%b exp=0", rdy_before); end
        if (u_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready_after_pop got=%b exp=1", u_if.in_ready); end
        break;
      end
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL simul_pop_seen got=none exp=start"); end
    tick();
    u_if.in_valid = 1'b0;
    wait_drained();
    n_tests += 2;
    if (st_cyc.size() != s0 + 6) begin n_fail++; $display("FAIL simul_issue_count got=%0d exp=6", st_cyc.size() - s0); end
    if (st_pair[st_pair.size()-1] !== pairs[5]) begin
      n_fail++; $display("FAIL simul_last_pair got=%h exp=%h", st_pair[st_pair.size()-1], pairs[5]);
    end
  endtask

  task automatic test_reset_mid_run();
    int s0, r0;
    bit seen;
    wait_drained();
    push_pair(8'h11, 8'h22);
    push_pair(8'h33, 8'h44);
    push_pair(8'h55, 8'h66);
    wait_start(seen);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests += 4;
    if (u_if.busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", u_if.busy); end
    if (u_if.in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", u_if.in_ready); end
    if ({u_if.op_a, u_if.op_b} !== 16'h0) begin n_fail++; $display("FAIL midrst_ops got=%h exp=0000", {u_if.op_a, u_if.op_b}); end
    if (u_if.res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_res_valid got=%b exp=0", u_if.res_valid); end
    s0 = st_cyc.size();
    r0 = rv_cnt;
    repeat (40) tick();
    n_tests += 2;
    if (st_cyc.size() != s0) begin n_fail++; $display("FAIL midrst_no_start got=%0d exp=0", st_cyc.size() - s0); end
    if (rv_cnt != r0)        begin n_fail++; $display("FAIL midrst_no_result got=%0d exp=0", rv_cnt - r0); end
  endtask

  task automatic test_random();
    int s0, r0, a0;
    wait_drained();
    s0 = st_cyc.size();
    r0 = rv_cnt;
    a0 = n_acc;
    for (int i = 0; i < 600; i++) begin
      int density;
      density = (i < 300) ? 1 : 6;
      u_if.in_valid = ($urandom_range(0, 7) < density);
      u_if.in_a = 8'($urandom);
      u_if.in_b = 8'($urandom);
      tick();
    end
    u_if.in_valid = 1'b0;
    wait_drained();
    n_tests += 3;
    if (n_acc == a0) begin n_fail++; $display("FAIL random_accepts got=0 exp=nonzero"); end
    if (st_cyc.size() - s0 != n_acc - a0) begin
      n_fail++; $display("FAIL random_issue_count got=%0d exp=%0d", st_cyc.size() - s0, n_acc - a0);
    end
    if (rv_cnt - r0 != n_acc - a0) begin
      n_fail++; $display("FAIL random_result_count got=%0d exp=%0d", rv_cnt - r0, n_acc - a0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_op();
    test_signed_passthrough();
    test_full_fifo();
    test_simul_push_pop();
    test_reset_mid_run();
    test_random();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
